// File: rtl/sr_bank_pkg.sv
// Shared definitions for the SR storage bank arbiter: operation encodings
// and default bank geometry.
package sr_bank_pkg;

   localparam int NREQ_DEF  = 4;
   localparam int WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      OP_HOLD   = 2'b00,
      OP_CLR    = 2'b01,
      OP_SET    = 2'b10,
      OP_TOGGLE = 2'b11
   } op_e;

endpackage

// File: rtl/sr_cell.sv
// One SR storage bit, clocked. The forbidden (1,1) input holds the
// current state and is flagged in simulation.
module sr_cell (
   input  logic clk,
   input  logic rst,
   input  logic s,
   input  logic r,
   output logic q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= 1'b0;
      end else begin
         case ({s, r})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            default: q <= q;
         endcase
      end
   end

   sr_forbidden_input: assert property (@(posedge clk) disable iff (rst) !(s && r));

endmodule

// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter granting NREQ requesters access to a bank of SR cells.
// A grant registered at one edge applies that requester's op at the next.
module sr_bank_arbiter
   import sr_bank_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NREQ-1:0]                req,
   input  logic [NREQ*$clog2(WIDTH)-1:0]  idx,
   input  logic [NREQ*2-1:0]              op,
   output logic [NREQ-1:0]                gnt,
   output logic [WIDTH-1:0]               q,
   output logic [WIDTH-1:0]               qn,
   output logic [15:0]                    ops_cnt
);

   localparam int IW = $clog2(WIDTH);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]  gnt_reg;
   logic [NREQ-1:0]  gnt_next;
   logic [PW-1:0]    ptr_reg;
   logic [PW-1:0]    ptr_next;
   logic [PW-1:0]    cand;
   logic             found;
   logic [15:0]      cnt_reg;
   logic [NREQ-1:0]  eligible;
   logic             active;
   logic [IW-1:0]    cur_idx;
   op_e              cur_op;
   logic [WIDTH-1:0] q_int;

   // The requester currently holding a grant is never eligible, so a lone
   // requester is served every second cycle.
   assign eligible = req & ~gnt_reg;
   assign active   = |gnt_reg;

   always_comb begin
      gnt_next = '0;
      ptr_next = ptr_reg;
      found    = 1'b0;
      cand     = '0;
      for (int off = 1; off <= NREQ; off++) begin
         cand = PW'((int'(ptr_reg) + off) % NREQ);
         if (!found && eligible[cand]) begin
            found          = 1'b1;
            gnt_next[cand] = 1'b1;
            ptr_next       = cand;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_reg <= '0;
         ptr_reg <= PW'(NREQ - 1);
         cnt_reg <= '0;
      end else begin
         gnt_reg <= gnt_next;
         ptr_reg <= ptr_next;
         if (active) begin
            cnt_reg <= cnt_reg + 16'd1;
         end
      end
   end

   always_comb begin
      cur_idx = '0;
      cur_op  = OP_HOLD;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_reg[i]) begin
            cur_idx = idx[i*IW +: IW];
            cur_op  = op_e'(op[i*2 +: 2]);
         end
      end
   end

   // An index outside the bank matches no cell and therefore acts as HOLD.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      logic s_c;
      logic r_c;

      always_comb begin
         s_c = 1'b0;
         r_c = 1'b0;
         if (active && cur_idx == IW'(gi)) begin
            case (cur_op)
               OP_CLR:    r_c = 1'b1;
               OP_SET:    s_c = 1'b1;
               OP_TOGGLE: begin
                  s_c = ~q_int[gi];
                  r_c = q_int[gi];
               end
               default:   ;
            endcase
         end
      end

      sr_cell u_cell (
         .clk (clk),
         .rst (rst),
         .s   (s_c),
         .r   (r_c),
         .q   (q_int[gi])
      );
   end

   assign gnt     = gnt_reg;
   assign q       = q_int;
   assign qn      = ~q_int;
   assign ops_cnt = cnt_reg;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Directed test of sr_bank_arbiter: reset, single op, toggle/clear chain,
// round-robin order, lone requester cadence, counter wrap and mid-grant reset.
module tb_sr_bank_arbiter;
   import sr_bank_pkg::*;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [11:0] idx;
   logic [7:0]  op;
   logic [3:0]  gnt;
   logic [7:0]  q;
   logic [7:0]  qn;
   logic [15:0] ops_cnt;

   int vectors;
   int miscompares;

   sr_bank_arbiter #(.NREQ(4), .WIDTH(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .idx     (idx),
      .op      (op),
      .gnt     (gnt),
      .q       (q),
      .qn      (qn),
      .ops_cnt (ops_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic set_rq(input int i, input logic [2:0] ix, input logic [1:0] o);
      req[i]         = 1'b1;
      idx[i*3 +: 3]  = ix;
      op[i*2 +: 2]   = o;
   endtask

   task automatic reset_pulse();
      req = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      idx         = '0;
      op          = '0;
      req         = 4'b1111;
      rst         = 1'b1;

      // Reset held two cycles with every requester active
      tick();
      tick();
      check("rst_q", q, 8'h00);
      check("rst_qn", qn, 8'hFF);
      check("rst_gnt", gnt, 4'b0000);
      check("rst_cnt", ops_cnt, 16'd0);
      rst = 1'b0;
      tick();
      check("rst_first_gnt", gnt, 4'b0001);
      req = '0;
      tick();
      check("rst_idle_gnt", gnt, 4'b0000);
      check("rst_cnt_after", ops_cnt, 16'd1);

      // Single SET from requester 2
      reset_pulse();
      set_rq(2, 3'd5, OP_SET);
      tick();
      check("single_gnt", gnt, 4'b0100);
      check("single_q_before", q, 8'h00);
      req = '0;
      tick();
      check("single_q", q, 8'h20);
      check("single_cnt", ops_cnt, 16'd1);
      check("single_gnt_off", gnt, 4'b0000);

      // Toggle / clear / toggle chain starting from q=8'h20
      set_rq(1, 3'd5, OP_TOGGLE);
      tick();
      check("tc_gnt1", gnt, 4'b0010);
      req = '0;
      set_rq(3, 3'd5, OP_CLR);
      tick();
      check("tc_q_toggle", q, 8'h00);
      check("tc_gnt3", gnt, 4'b1000);
      req = '0;
      set_rq(0, 3'd0, OP_TOGGLE);
      tick();
      check("tc_q_clr", q, 8'h00);
      check("tc_gnt0", gnt, 4'b0001);
      req = '0;
      tick();
      check("tc_q_toggle0", q, 8'h01);
      check("tc_qn", qn, 8'hFE);
      check("tc_cnt", ops_cnt, 16'd4);

      // Round-robin with all four requesters issuing HOLD
      reset_pulse();
      op  = '0;
      req = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("rr_gnt_%0d", i), gnt, 32'(4'b0001 << (i % 4)));
         check($sformatf("rr_cnt_%0d", i), ops_cnt, i);
      end
      req = '0;
      tick();
      check("rr_q", q, 8'h00);
      check("rr_cnt_end", ops_cnt, 16'd8);

      // Lone requester is granted every second cycle
      reset_pulse();
      set_rq(0, 3'd2, OP_HOLD);
      for (int i = 1; i <= 6; i++) begin
         tick();
         check($sformatf("lone_gnt_%0d", i), gnt, (i % 2 == 1) ? 32'd1 : 32'd0);
         check($sformatf("lone_cnt_%0d", i), ops_cnt, i / 2);
      end
      req = '0;

      // ops_cnt wrap from 16'hFFFF
      reset_pulse();
      force dut.cnt_reg = 16'hFFFF;
      #1;
      release dut.cnt_reg;
      #1;
      check("wrap_preload", ops_cnt, 16'hFFFF);
      set_rq(0, 3'd1, OP_HOLD);
      tick();
      check("wrap_gnt", gnt, 4'b0001);
      req = '0;
      tick();
      check("wrap_cnt", ops_cnt, 16'h0000);

      // Reset during a pending SET grant discards the op
      set_rq(1, 3'd3, OP_SET);
      tick();
      check("mid_gnt", gnt, 4'b0010);
      rst = 1'b1;
      #1;
      check("mid_gnt_cleared", gnt, 4'b0000);
      req = '0;
      tick();
      rst = 1'b0;
      tick();
      check("mid_q", q, 8'h00);
      check("mid_cnt", ops_cnt, 16'd0);
      set_rq(1, 3'd3, OP_SET);
      tick();
      check("mid_regrant", gnt, 4'b0010);
      req = '0;
      tick();
      check("mid_q_set", q, 8'h08);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sr_bank_arbiter.md
SR_BANK_ARBITER -- requirements
Module: sr_bank_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters.
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning the number of SR storage cells in the bank.
REQ-003 The block SHALL have the following ports (name  direction  width  meaning):
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req  input  NREQ  per-requester request, level.
- idx  input  NREQ*$clog2(WIDTH)  packed per-requester target cell index; requester i occupies slice i.
- op  input  NREQ*2  packed per-requester operation; requester i occupies slice i.
- gnt  output  NREQ  one-hot grant, registered.
- q  output  WIDTH  bank state.
- qn  output  WIDTH  ~q, combinational.
- ops_cnt  output  16  count of applied operations.

Function
REQ-004 Operation encoding SHALL be: 00 HOLD, 01 CLR, 10 SET, 11 TOGGLE.
REQ-005 The block SHALL drive each bank cell with an (s,r) pair as follows:
- HOLD gives (0,0).
- CLR gives (0,1).
- SET gives (1,0).
- TOGGLE gives (~q[k], q[k]).
- Untargeted cells get (0,0).
- (1,1) SHALL never be driven to any cell.
REQ-006 Each cell SHALL update on the rising edge: (0,0) holds, (0,1) gives 0, (1,0) gives 1.
REQ-007 Arbitration SHALL be round-robin over eligible requesters, starting the search at the index after the last granted requester (the pointer).
REQ-008 A requester is eligible at an edge iff its req is 1 and its gnt is currently 0.
REQ-009 At most one gnt bit SHALL be high in any cycle.
REQ-010 gnt SHALL be registered:
- A requester chosen at edge k has gnt high from edge k to edge k+1.
- Its idx/op are sampled at edge k+1.
- The op is applied to q at edge k+1, giving one-cycle latency from gnt rising to q change.
REQ-011 Requesters SHALL hold req, idx and op stable from assertion until the cycle gnt is high; values outside that window are don't-care.
REQ-012 A requester holding req high continuously SHALL be granted at most every second cycle; with two or more requesters active, grants SHALL be back-to-back every cycle.
REQ-013 The round-robin pointer SHALL update to the granted index on each grant and SHALL hold when no grant is issued.
REQ-014 If no requester is eligible, gnt SHALL be all-zero at the next edge.
REQ-015 An idx value of WIDTH or greater SHALL be treated as HOLD: q is unchanged and ops_cnt is still incremented.
REQ-016 ops_cnt SHALL increment by 1 at every edge where a granted op is applied, including HOLD, and SHALL wrap from 16'hFFFF to 0.
REQ-017 Deassertion of req while gnt is high SHALL NOT cancel the grant: the sampled op is still applied.

Reset
REQ-018 While rst is high:
- q = 0 and qn = all ones.
- gnt = 0.
- ops_cnt = 0.
- The pointer is set so that requester 0 has highest priority.
REQ-019 Reset asserted mid-grant SHALL discard the pending op; after rst falls, the first grant SHALL occur at the first edge with an eligible requester.

Structure
REQ-020 Package sr_bank_pkg SHALL hold the op encodings (OP_HOLD, OP_CLR, OP_SET, OP_TOGGLE) and the defaults for NREQ/WIDTH.
REQ-021 Each storage bit SHALL be an instance of sub-module sr_cell with ports clk, rst, s, r, q.
- sr_cell SHALL hold its state on the forbidden (1,1) input.
- sr_cell SHALL carry a simulation-only assertion that flags any (1,1) input.
REQ-022 The arbiter, op decoder and ops_cnt SHALL reside in sr_bank_arbiter; the design SHALL contain no latches.

Verification
REQ-023 Reset: rst=1 for 2 cycles with all req high -> q=8'h00, qn=8'hFF, gnt=0, ops_cnt=0; the first grant after release goes to requester 0.
REQ-024 Single op: req[2]=1, idx=5, op=SET -> gnt=4'b0100 for one cycle, then q=8'h20 and ops_cnt=1.
REQ-025 Round-robin: req=4'b1111 held, all ops HOLD -> grant sequence 0,1,2,3,0,...; exactly one gnt bit per cycle; ops_cnt increments every cycle.
REQ-026 Toggle and clear: q=8'h20; requester 1 TOGGLE idx 5, then requester 3 CLR idx 5, then requester 0 TOGGLE idx 0 -> q goes 8'h00, 8'h00, 8'h01; no sr_cell (1,1) assertion fires.
REQ-027 Lone requester: req=4'b0001 held -> gnt[0] alternates 1,0,1,0; ops_cnt advances every second cycle.
REQ-028 Boundaries:
- ops_cnt preloaded by forcing to 16'hFFFF, then one grant -> ops_cnt=0.
- rst pulsed while gnt[1]=1 with op=SET -> q stays 8'h00 after release.
